// File: rtl/alu_exec_if.sv
// rtl/alu_exec_if.sv - request/response bundle between the issue logic and alu_exec
//
// Signals:
//   start, aluctl, a, b             request side (driven by master)
//   busy, done, result, zero,
//   overflow                        response side (driven by slave, alu_exec)
interface alu_exec_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       aluctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;

    modport master (
        output start, aluctl, a, b,
        input  busy, done, result, zero, overflow
    );

    modport slave (
        input  start, aluctl, a, b,
        output busy, done, result, zero, overflow
    );
endinterface

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - registered execute-stage ALU with iterative shift-add multiply
//
// Ports:
//   clk       rising-edge clock
//   reset_n   synchronous active-low reset
//   bus       alu_exec_if.slave: start/aluctl/a/b in; busy/done/result/zero/overflow out
// Parameters:
//   WIDTH     operand/result width (>= 2)
//   CNT_W     iteration counter width (2**CNT_W > WIDTH)
// Optional feature macro:
//   ALU_MUL_EARLY_EXIT_EN  finish MUL as soon as the remaining multiplier bits are all zero
module alu_exec #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic      clk,
    input  logic      reset_n,
    alu_exec_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_OR  = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_MUL = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h6;
    localparam logic [3:0] OP_SLT = 4'h7;
    localparam logic [3:0] OP_NOR = 4'hC;
    localparam logic [3:0] OP_XOR = 4'hD;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t           state;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             overflow_q;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] op_res;
    logic             op_ovf;

    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] mplier_next;
    logic             last_iter;

    // Single-cycle datapath, evaluated from the live request operands.
    always_comb begin
        sum    = bus.a + bus.b;
        diff   = bus.a - bus.b;
        op_res = '0;
        op_ovf = 1'b0;
        case (bus.aluctl)
            OP_AND: op_res = bus.a & bus.b;
            OP_OR:  op_res = bus.a | bus.b;
            OP_ADD: begin
                op_res = sum;
                op_ovf = (bus.a[MSB] == bus.b[MSB]) && (sum[MSB] != bus.a[MSB]);
            end
            OP_SUB: begin
                op_res = diff;
                op_ovf = (bus.a[MSB] != bus.b[MSB]) && (diff[MSB] != bus.a[MSB]);
            end
            OP_SLT: op_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_NOR: op_res = ~(bus.a | bus.b);
            OP_XOR: op_res = bus.a ^ bus.b;
            default: ;
        endcase
    end

    // One shift-add step on the captured operands.
    always_comb begin
        acc_next    = mplier[0] ? (acc + mcand) : acc;
        mplier_next = mplier >> 1;
`ifdef ALU_MUL_EARLY_EXIT_EN
        // Once every remaining multiplier bit is zero the accumulator is final;
        // the counter bound is kept so the loop can never run past WIDTH steps.
        last_iter   = (mplier_next == '0) || (cnt == CNT_W'(WIDTH - 1));
`else
        last_iter   = (cnt == CNT_W'(WIDTH - 1));
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            cnt        <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.aluctl == OP_MUL) begin
                            acc    <= '0;
                            mcand  <= bus.a;
                            mplier <= bus.b;
                            cnt    <= '0;
                            busy_q <= 1'b1;
                            state  <= S_MUL;
                        end else begin
                            result_q   <= op_res;
                            zero_q     <= (op_res == '0);
                            overflow_q <= op_ovf;
                            done_q     <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    // start is deliberately not looked at here: the unit is busy.
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier_next;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        result_q   <= acc_next;
                        zero_q     <= (acc_next == '0);
                        overflow_q <= 1'b0;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - self-checking bench for alu_exec against an arithmetic reference model
module tb_alu_exec;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    alu_exec_if #(.WIDTH(W)) bus ();

    alu_exec #(.WIDTH(W), .CNT_W(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the opcode table.
    function automatic logic [W-1:0] ref_result(input logic [3:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        logic [2*W-1:0] prod;
        case (op)
            4'h0: return a & b;
            4'h1: return a | b;
            4'h2: return W'(a + b);
            4'h6: return W'(a - b);
            4'h7: return (sa < sb) ? W'(1) : W'(0);
            4'hC: return ~(a | b);
            4'hD: return a ^ b;
            4'h3: begin
                prod = (2*W)'(a) * (2*W)'(b);
                return prod[W-1:0];
            end
            default: return '0;
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [3:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint r;
        longint maxv = (longint'(1) <<< (W-1)) - 1;
        longint minv = -(longint'(1) <<< (W-1));
        if (op == 4'h2) r = sa + sb;
        else if (op == 4'h6) r = sa - sb;
        else return 1'b0;
        return (r > maxv) || (r < minv);
    endfunction

    function automatic int ref_mul_latency(input logic [W-1:0] b);
`ifdef ALU_MUL_EARLY_EXIT_EN
        int hi = 0;
        for (int i = 0; i < W; i++) if (b[i]) hi = i + 1;
        return (hi < 1) ? 1 : hi;
`else
        return W;
`endif
    endfunction

    // Issue one operation and check the completion. For MUL, junk start pulses with
    // scrambled operands are injected while busy to show they are ignored.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit junk);
        logic [W-1:0] er = ref_result(op, a, b);
        int k = 0;
        int lat;
        @(negedge clk);
        bus.start = 1'b1; bus.aluctl = op; bus.a = a; bus.b = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        if (op == 4'h3) begin
            lat = ref_mul_latency(b);
            if (lat > 1) check({tag, "_busy"}, 64'(bus.busy), 64'd1);
            while (!bus.done && k < W + 4) begin
                if (junk && $urandom_range(0, 2) == 0) begin
                    bus.start = 1'b1; bus.aluctl = 4'($urandom_range(0, 15));
                    bus.a = $urandom; bus.b = $urandom;
                end
                @(posedge clk);
                @(negedge clk);
                bus.start = 1'b0;
                k++;
            end
            check({tag, "_lat"}, 64'(k), 64'(lat));
        end
        check({tag, "_done"}, 64'(bus.done), 64'd1);
        check({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
        check({tag, "_res"}, 64'(bus.result), 64'(er));
        check({tag, "_zero"}, 64'(bus.zero), 64'(er == '0));
        check({tag, "_ovf"}, 64'(bus.overflow), 64'(ref_ovf(op, a, b)));
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        check({tag, "_hold"}, 64'(bus.result), 64'(er));
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return W'(1);
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            5: return W'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #900000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] ops [8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'hC, 4'hD};
        int pulses;

        bus.start = 1'b0; bus.aluctl = 4'h0; bus.a = '0; bus.b = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_zero", 64'(bus.zero), 64'd0);
        check("rst_ovf", 64'(bus.overflow), 64'd0);
        reset_n = 1'b1;

        // Reset aborts a multiply in flight.
        @(negedge clk);
        bus.start = 1'b1; bus.aluctl = 4'h3; bus.a = 7; bus.b = 9;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_result", 64'(bus.result), 64'd0);
        check("abort_zero", 64'(bus.zero), 64'd0);
        reset_n = 1'b1;
        pulses = 0;
        repeat (W + 8) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("abort_no_done", 64'(pulses), 64'd0);

        // Directed cases.
        do_op("add_ovf", 4'h2, 32'h7FFF_FFFF, 32'h1, 1'b0);
        check("add_ovf_const", 64'(bus.result), 64'h8000_0000);

        @(negedge clk);
        bus.start = 1'b1; bus.aluctl = 4'h6; bus.a = 5; bus.b = 5;
        @(posedge clk);
        @(negedge clk);
        bus.aluctl = 4'h7; bus.a = 32'hFFFF_FFFF; bus.b = 1;
        check("b2b_sub_done", 64'(bus.done), 64'd1);
        check("b2b_sub_res", 64'(bus.result), 64'd0);
        check("b2b_sub_zero", 64'(bus.zero), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_slt_done", 64'(bus.done), 64'd1);
        check("b2b_slt_res", 64'(bus.result), 64'd1);
        check("b2b_slt_zero", 64'(bus.zero), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("b2b_done_low", 64'(bus.done), 64'd0);

        do_op("mul", 4'h3, 32'd1234, 32'd5678, 1'b1);
        check("mul_const", 64'(bus.result), 64'd7006652);
        do_op("mul_wrap", 4'h3, 32'h8000_0000, 32'd2, 1'b0);
        check("mul_wrap_const", 64'(bus.result), 64'd0);
        do_op("mul_b0", 4'h3, 32'd99, 32'd0, 1'b0);
        do_op("mul_b1", 4'h3, 32'd99, 32'd1, 1'b0);
        do_op("mul_b5", 4'h3, 32'd11, 32'd5, 1'b0);
        do_op("bad_op", 4'hF, 32'd3, 32'd4, 1'b0);
        check("bad_op_zero", 64'(bus.zero), 64'd1);

        // Randomized operations.
        for (int i = 0; i < 120; i++) begin
            int r = $urandom_range(0, 9);
            logic [3:0] op = (r < 8) ? ops[r] : 4'($urandom_range(0, 15));
            do_op("rnd", op, pick_operand(), pick_operand(), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
